// File: rtl/play_pkg.sv
// Shared play-controller definitions: game status codes,
// direction indices, one-hot move codes and a priority picker.
package play_pkg;

    typedef enum logic [1:0] {
        CHOSE_BOARD  = 2'b00,
        GAMING       = 2'b01,
        GAME_INITIAL = 2'b10,
        WINNED       = 2'b11
    } game_status_e;

    localparam int DIR_UP    = 0;
    localparam int DIR_RIGHT = 1;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 3;

    localparam logic [3:0] ACT_NONE  = 4'b0000;
    localparam logic [3:0] ACT_UP    = 4'b0001;
    localparam logic [3:0] ACT_RIGHT = 4'b0010;
    localparam logic [3:0] ACT_DOWN  = 4'b0100;
    localparam logic [3:0] ACT_LEFT  = 4'b1000;

    // Keep only the highest-priority press: up > right > down > left.
    function automatic logic [3:0] dir_pick(input logic [3:0] p);
        logic [3:0] r;
        r = ACT_NONE;
        if (p[DIR_UP])
            r = ACT_UP;
        else if (p[DIR_RIGHT])
            r = ACT_RIGHT;
        else if (p[DIR_DOWN])
            r = ACT_DOWN;
        else if (p[DIR_LEFT])
            r = ACT_LEFT;
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: 2-FF synchroniser, counting debounce
// and a registered one-cycle pulse on each debounced rising edge.
module key_debounce
    import play_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic clk_d,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic          prev_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count cycles of disagreement; flip the stable level when the run is long enough.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1))
                stable_d = sync2_q;
            else
                cnt_d = cnt_q + CW'(1);
        end
    end

    // Synchroniser, debounce state and rise-pulse register.
    always_ff @(posedge clk_d) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            press_q  <= stable_q & ~prev_q;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign press  = press_q;

endmodule

// File: rtl/move_input_conditioner.sv
// Button front end: debounces 4 directions + restart, emits gated one-cycle commands.
// Optional auto-repeat of a held direction when MOVE_AUTO_REPEAT_EN is defined.
module move_input_conditioner
    import play_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 150
) (
    input  logic       clk_d,
    input  logic       rst_n,
    input  logic [3:0] btn_dir,
    input  logic       btn_restart,
    input  logic [1:0] game_status,
    output logic [3:0] act,
    output logic       active,
    output logic       restart
);

    logic [3:0] dir_stable;
    logic [3:0] dir_press;
    logic       rst_stable;
    logic       rst_press;
    logic       gaming;
    logic [3:0] pick;

    logic [3:0] act_q, act_d;
    logic       active_q, active_d;
    logic       restart_q, restart_d;

    for (genvar i = 0; i < 4; i++) begin : g_dir
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk_d  (clk_d),
            .rst_n  (rst_n),
            .raw    (btn_dir[i]),
            .stable (dir_stable[i]),
            .press  (dir_press[i])
        );
    end

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_rst (
        .clk_d  (clk_d),
        .rst_n  (rst_n),
        .raw    (btn_restart),
        .stable (rst_stable),
        .press  (rst_press)
    );

    logic unused_lvl;
    assign unused_lvl = ^{rst_stable, dir_stable};

    assign gaming = (game_status == GAMING);
    assign pick   = dir_pick(dir_press);

`ifdef MOVE_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic [3:0]    rep_dir_q, rep_dir_d;
    logic          rep_first_q, rep_first_d;
    logic [RW-1:0] rep_lim;

    assign rep_lim = rep_first_q ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
`else
    localparam int unused_rep = REPEAT_DELAY + REPEAT_PERIOD;
`endif

    // Gate, prioritise and (optionally) auto-repeat into next-state outputs.
    always_comb begin
        act_d     = ACT_NONE;
        active_d  = 1'b0;
        restart_d = 1'b0;
        if (gaming) begin
            if (rst_press) begin
                restart_d = 1'b1;
            end else if (pick != ACT_NONE) begin
                act_d    = pick;
                active_d = 1'b1;
            end
        end
`ifdef MOVE_AUTO_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_dir_d   = rep_dir_q;
        rep_first_d = rep_first_q;
        if (!gaming || rst_press) begin
            rep_dir_d = ACT_NONE;
            rep_cnt_d = '0;
        end else if (active_d) begin
            rep_dir_d   = pick;
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
        end else if (rep_dir_q != ACT_NONE) begin
            if (dir_stable != rep_dir_q) begin
                rep_dir_d = ACT_NONE;
                rep_cnt_d = '0;
            end else if (rep_cnt_q == rep_lim) begin
                act_d       = rep_dir_q;
                active_d    = 1'b1;
                rep_cnt_d   = '0;
                rep_first_d = 1'b0;
            end else begin
                rep_cnt_d = rep_cnt_q + RW'(1);
            end
        end
`endif
    end

    // Registered command outputs.
    always_ff @(posedge clk_d) begin
        if (!rst_n) begin
            act_q     <= ACT_NONE;
            active_q  <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            act_q     <= act_d;
            active_q  <= active_d;
            restart_q <= restart_d;
        end
    end

`ifdef MOVE_AUTO_REPEAT_EN
    // Auto-repeat tracking for the currently held direction.
    always_ff @(posedge clk_d) begin
        if (!rst_n) begin
            rep_cnt_q   <= '0;
            rep_dir_q   <= ACT_NONE;
            rep_first_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_dir_q   <= rep_dir_d;
            rep_first_q <= rep_first_d;
        end
    end
`endif

    assign act     = act_q;
    assign active  = active_q;
    assign restart = restart_q;

endmodule

// File: tb/tb_move_input_conditioner.sv
// Scoreboard bench for move_input_conditioner (DEBOUNCE=4, REPEAT 10/5).
module tb_move_input_conditioner;

    localparam int D   = 4;
    localparam int LAT = D + 4;

    logic       clk_d = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_dir = 4'b0000;
    logic       btn_restart = 1'b0;
    logic [1:0] game_status = 2'b01;
    logic [3:0] act;
    logic       active;
    logic       restart;

    move_input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk_d       (clk_d),
        .rst_n       (rst_n),
        .btn_dir     (btn_dir),
        .btn_restart (btn_restart),
        .game_status (game_status),
        .act         (act),
        .active      (active),
        .restart     (restart)
    );

    always #5 clk_d = ~clk_d;

    int ecount = 0;
    always @(posedge clk_d) ecount <= ecount + 1;

    int vectors = 0;
    int errors  = 0;
    bit mon_en  = 1'b0;

    typedef struct {
        int         t;
        logic [3:0] a;
        logic       mv;
        logic       rs;
    } exp_t;

    exp_t sb[$];
    exp_t em;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at count %0d: got %0h, want %0h", name, ecount, got, exp);
        end
    endtask

    task automatic push(input int t, input logic [3:0] a, input logic mv, input logic rs);
        exp_t e;
        e.t  = t;
        e.a  = a;
        e.mv = mv;
        e.rs = rs;
        sb.push_back(e);
    endtask

    task automatic wait_to(input int n);
        while (ecount < n) @(negedge clk_d);
    endtask

    always @(negedge clk_d) begin
        if (mon_en) begin
            if (active || restart) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {26'd0, act, active, restart}, 32'd0);
                end else begin
                    em = sb.pop_front();
                    check("pulse_time", ecount, em.t);
                    check("act", {28'd0, act}, {28'd0, em.a});
                    check("active", {31'd0, active}, {31'd0, em.mv});
                    check("restart", {31'd0, restart}, {31'd0, em.rs});
                end
            end else if (sb.size() > 0 && sb[0].t <= ecount) begin
                em = sb.pop_front();
                check("missed_pulse", ecount, em.t + 1000000);
            end
            if (!active && act != 4'b0000)
                check("act_idle", {28'd0, act}, 32'd0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    int n, m, x;

    initial begin
        repeat (2) @(negedge clk_d);
        check("rst_act", {28'd0, act}, 32'd0);
        check("rst_active", {31'd0, active}, 32'd0);
        check("rst_restart", {31'd0, restart}, 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk_d);

        // clean press of right
        n = ecount;
        btn_dir = 4'b0010;
        push(n + LAT, 4'b0010, 1'b1, 1'b0);
        wait_to(n + 10);
        btn_dir = 4'b0000;
        wait_to(n + 34);

        // bounce on up: 3 high, 1 low, 2 high, low
        for (int k = 0; k < 16; k++) begin
            btn_dir[0] = (k < 3) || (k >= 4 && k < 6);
            @(negedge clk_d);
            check("bounce_stable", {31'd0, dut.dir_stable[0]}, 32'd0);
        end
        btn_dir = 4'b0000;

        // simultaneous down+left
        n = ecount;
        btn_dir = 4'b1100;
        push(n + LAT, 4'b0100, 1'b1, 1'b0);
        wait_to(n + 10);
        btn_dir = 4'b0000;
        wait_to(n + 34);

        // restart with right on the same edge
        n = ecount;
        btn_restart = 1'b1;
        btn_dir = 4'b0010;
        push(n + LAT, 4'b0000, 1'b0, 1'b1);
        wait_to(n + 10);
        btn_restart = 1'b0;
        btn_dir = 4'b0000;
        wait_to(n + 34);

        // gating: press under CHOSE_BOARD, hold into GAMING
        game_status = 2'b00;
        n = ecount;
        btn_dir = 4'b0001;
        wait_to(n + 15);
        game_status = 2'b01;
        wait_to(n + 25);
        btn_dir = 4'b0000;
        wait_to(n + 37);
        m = ecount;
        btn_dir = 4'b0001;
        push(m + LAT, 4'b0001, 1'b1, 1'b0);
        wait_to(m + 10);
        btn_dir = 4'b0000;
        wait_to(m + 34);

        // reset two cycles into a left press, held
        n = ecount;
        btn_dir = 4'b1000;
        wait_to(n + 2);
        rst_n = 1'b0;
        wait_to(n + 3);
        check("midrst_act", {28'd0, act}, 32'd0);
        check("midrst_active", {31'd0, active}, 32'd0);
        check("midrst_restart", {31'd0, restart}, 32'd0);
        rst_n = 1'b1;
        x = n + 3 + LAT;
        push(x, 4'b1000, 1'b1, 1'b0);
`ifdef MOVE_AUTO_REPEAT_EN
        push(x + 10, 4'b1000, 1'b1, 1'b0);
        push(x + 15, 4'b1000, 1'b1, 1'b0);
        push(x + 20, 4'b1000, 1'b1, 1'b0);
`endif
        wait_to(x + 17);
        btn_dir = 4'b0000;
        wait_to(x + 40);

        check("drain", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/move_input_conditioner.md
Name: move_input_conditioner

Overview:
- Upstream front end of the 2x2 sliding-tile play controller; converts raw direction/restart push-buttons into clean single-cycle commands.
- Per button: 2-FF synchroniser and debounce.
- Outputs a one-hot move code `act[3:0]` with a one-cycle `active` strobe, plus a one-cycle `restart` strobe.
- Emits commands only while game_status is GAMING; the play controller consumes them directly.

Parameters:
- DEBOUNCE_CYCLES, 20: consecutive clk_d cycles a synchronised level must differ from the stable level before the stable level flips.
- REPEAT_DELAY, 500: cycles a direction is held before the first auto-repeat (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 150: cycles between subsequent auto-repeats (AUTO_REPEAT_EN only).

Ports:
- clk_d, input, 1: game clock (divided system clock).
- rst_n, input, 1: synchronous, active-low reset, sampled on posedge clk_d.
- btn_dir, input, 4: raw direction buttons, asynchronous, active-high. [0]=up, [1]=right, [2]=down, [3]=left.
- btn_restart, input, 1: raw restart button, asynchronous, active-high.
- game_status, input, 2: 00 CHOSE_BOARD, 01 GAMING, 10 GAME_INITIAL, 11 WINNED.
- act, output, 4: one-hot move code, valid only while active=1, otherwise 4'b0000.
- active, output, 1: one-cycle move strobe.
- restart, output, 1: one-cycle restart strobe.

Behaviour:
- Single clock domain. Reset is synchronous and active-low. All state is reset: sync FFs, stable levels, counters, act=0, active=0, restart=0.
- Per channel (5 channels): sync1 <= raw; sync2 <= sync1.
  - Counter clears on any cycle where sync2 == stable.
  - Otherwise the counter increments. On the edge where it would reach DEBOUNCE_CYCLES, stable <= sync2 and the counter clears.
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
- Press event: stable transitions 0->1. A release (1->0) produces nothing.
- Outputs are registered, driven from the press event on the edge after stable flips.
  - Latency: active/restart go high for exactly one cycle, starting DEBOUNCE_CYCLES+3 edges after the first edge that samples the raw button high.
  - This assumes the raw level holds steady throughout.
- A glitch shorter than DEBOUNCE_CYCLES cycles on sync2 causes no stable change and no output.
- Simultaneous direction press events in one cycle: only the highest-priority one is emitted (up > right > down > left). The others are discarded, not queued.
- Restart has priority over moves. If restart and a move fire in the same cycle, restart=1 and active=0, act=0.
- Gating:
  - While game_status != GAMING, press events are dropped (not deferred).
  - Debounce keeps running regardless of game_status.
  - A button held across entry into GAMING produces no output until it is released and pressed again.
- A button held through reset release is treated as a new press: stable resets to 0, so it fires after debounce if status is GAMING.
- active and restart are never high in consecutive cycles from the same channel. A new press requires a debounced release first, except for auto-repeat.

Optional Feature:
- Macro: MOVE_AUTO_REPEAT_EN.
- Defined:
  - Holding a single direction (stable=1, no other direction stable) for REPEAT_DELAY cycles after its press event emits another act/active pulse.
  - Further pulses follow every REPEAT_PERIOD cycles while held.
  - The repeat counter clears on release, on any other direction becoming stable, on restart, on game_status leaving GAMING, and on reset.
  - Restart never repeats.
- Undefined: no repeat logic is synthesised; behaviour is exactly as above.

Decomposition:
- Shared package play_pkg:
  - game_status codes: CHOSE_BOARD, GAMING, GAME_INITIAL, WINNED.
  - Direction bit indices DIR_UP=0, DIR_RIGHT=1, DIR_DOWN=2, DIR_LEFT=3.
  - One-hot act constants.
- Sub-module key_debounce, parameter DEBOUNCE_CYCLES:
  - Ports clk_d, rst_n, raw; outputs stable and press (one-cycle rise pulse).
  - Instantiated 5 times.
- Top level holds priority encoding, gating, output registers and the optional repeat counter.

Test Plan:
All tests use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
- Clean press: status=01, btn_dir=4'b0010 from edge 0, held. Expect act=4'b0010, active=1 only in cycle 7, then act=0, active=0.
- Bounce: btn_dir[0] high for 3 cycles, low 1, high 2, then low. Expect active never asserts and stable[0] stays 0.
- Simultaneous press: btn_dir=4'b1100 rises on the same edge. Expect act=4'b0100 once; left is never emitted, even while still held.
- Restart priority: btn_restart and btn_dir[1] rise on the same edge. Expect restart=1, active=0 in the same cycle; no later move pulse.
- Gating: status=00 during a press and held, then status=01. Expect no output. Release, then press again: act pulses 7 edges after the re-press.
- Reset mid-debounce: rst_n=0 for 1 cycle, asserted 2 cycles into a press. Expect all outputs 0; the held button fires 7 edges after rst_n returns high. With MOVE_AUTO_REPEAT_EN, continue holding: repeat pulses at +10 and then every +5 cycles.
